// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN front-end blocks.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned IMG_W      = 8;
  localparam int unsigned IMG_H      = 8;
  localparam int unsigned K          = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Row/column/tap counters for the window walk and the registered buffer read address.
module window_addr_gen #(
  parameter  int unsigned SIZE  = 64,
  parameter  int unsigned IMG_W = 8,
  parameter  int unsigned IMG_H = 8,
  parameter  int unsigned K     = 3,
  localparam int unsigned AW    = $clog2(SIZE),
  localparam int unsigned RW    = $clog2(IMG_H),
  localparam int unsigned CW    = $clog2(IMG_W),
  localparam int unsigned TW    = (K > 1) ? $clog2(K * K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          tap_step_i,
  input  logic          win_step_i,
  input  logic          addr_en_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [TW-1:0] tap_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_tap_o,
  output logic          last_win_o
);

  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned AWX = AW + 1;

  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [KW-1:0]  kr_q, kr_d;
  logic [KW-1:0]  kc_q, kc_d;
  logic [TW-1:0]  tap_q, tap_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AWX-1:0] addr_full;

  assign last_tap_o = (tap_q == TW'(K * K - 1));
  assign last_win_o = (row_q == RW'(IMG_H - K)) && (col_q == CW'(IMG_W - K));

  assign rd_addr_o = addr_q;
  assign tap_o     = tap_q;
  assign row_o     = row_q;
  assign col_o     = col_q;

  // Counter advance and address of the tap that will be read next cycle.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    kr_d  = kr_q;
    kc_d  = kc_q;
    tap_d = tap_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      kr_d  = '0;
      kc_d  = '0;
      tap_d = '0;
    end else begin
      if (tap_step_i) begin
        if (last_tap_o) begin
          tap_d = '0;
          kr_d  = '0;
          kc_d  = '0;
        end else begin
          tap_d = tap_q + TW'(1);
          if (kc_q == KW'(K - 1)) begin
            kc_d = '0;
            kr_d = kr_q + KW'(1);
          end else begin
            kc_d = kc_q + KW'(1);
          end
        end
      end
      if (win_step_i) begin
        if (col_q == CW'(IMG_W - K)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
    // One spare bit of headroom; valid positions always fit in AW bits.
    addr_full = (AWX'(row_d) + AWX'(kr_d)) * AWX'(IMG_W) + AWX'(col_d) + AWX'(kc_d);
    addr_d    = addr_en_i ? addr_full[AW-1:0] : '0;
  end

  // Counter and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      kr_q   <= '0;
      kc_q   <= '0;
      tap_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      kr_q   <= kr_d;
      kc_q   <= kc_d;
      tap_q  <= tap_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/conv_window_fetch.sv
// Walks all stride-1 KxK windows of the input buffer and hands each out as one packed word.
module conv_window_fetch #(
  parameter  int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter  int unsigned SIZE       = 64,
  parameter  int unsigned IMG_W      = cnn_pkg::IMG_W,
  parameter  int unsigned IMG_H      = cnn_pkg::IMG_H,
  parameter  int unsigned K          = cnn_pkg::K,
  localparam int unsigned AW         = $clog2(SIZE),
  localparam int unsigned RW         = $clog2(IMG_H),
  localparam int unsigned CW         = $clog2(IMG_W),
  localparam int unsigned WW         = K * K * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [WW-1:0]         win_data,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col
);

  import cnn_pkg::*;

  localparam int unsigned TW = (K > 1) ? $clog2(K * K) : 1;

  fetch_state_t state_q, state_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [WW-1:0] win_data_q, win_data_d;

  logic [TW-1:0] tap;
  logic          last_tap;
  logic          last_win;
  logic          accept;
  logic          clear;
  logic          tap_step;
  logic          win_step;
  logic          addr_en;

  // In HOLD the window is always valid, so ready alone completes the handshake.
  assign accept   = (state_q == HOLD) && win_ready;
  assign clear    = (state_q == IDLE);
  assign tap_step = (state_q == FETCH);
  assign win_step = accept && !last_win;
  assign addr_en  = (state_d == FETCH);

  window_addr_gen #(
    .SIZE  (SIZE),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .tap_step_i (tap_step),
    .win_step_i (win_step),
    .addr_en_i  (addr_en),
    .rd_addr_o  (rd_addr),
    .tap_o      (tap),
    .row_o      (win_row),
    .col_o      (win_col),
    .last_tap_o (last_tap),
    .last_win_o (last_win)
  );

  // Next state plus registered status flags derived from it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_tap) state_d = HOLD;
      HOLD:    if (accept) state_d = last_win ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == FETCH) || (state_d == HOLD);
    valid_d = (state_d == HOLD);
    done_d  = (state_d == DONE);
  end

  // Capture the buffer data for the current tap into its slot of the window word.
  always_comb begin
    win_data_d = win_data_q;
    if (state_q == FETCH) begin
      win_data_d[tap * DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end
  end

  // State, flag and window registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      win_data_q <= win_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_valid = valid_q;
  assign win_data  = win_data_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: default 8x8/K=3 instance and a 5x4/K=2 instance.
`timescale 1ns/1ps
module tb_conv_window_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry instance
  logic        rst, start, busy, done, win_valid, win_ready;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [71:0] win_data;
  logic [2:0]  win_row, win_col;
  logic [7:0]  buf_a [64];

  // Small-geometry instance
  logic        rst_b, start_b, busy_b, done_b, win_valid_b, win_ready_b;
  logic [4:0]  rd_addr_b;
  logic [7:0]  rd_data_b;
  logic [31:0] win_data_b;
  logic [1:0]  win_row_b;
  logic [2:0]  win_col_b;
  logic [7:0]  buf_b [20];

  assign rd_data   = buf_a[rd_addr];
  assign rd_data_b = buf_b[rd_addr_b];

  conv_window_fetch dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col)
  );

  conv_window_fetch #(.DATA_WIDTH(8), .SIZE(20), .IMG_W(5), .IMG_H(4), .K(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .win_data(win_data_b), .win_row(win_row_b), .win_col(win_col_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame record filled by drive_frame
  int          n_hs, done_cyc, first_valid_cyc, done_pulses;
  bit          busy_at_done, frozen_ok;
  int          hs_row [64];
  int          hs_col [64];
  int          hs_cyc [64];
  logic [71:0] hs_data [64];

  function automatic logic [71:0] exp_a(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        w[(kr * 3 + kc) * 8 +: 8] = 8'((r + kr) * 8 + c + kc);
    return w;
  endfunction

  // Runs one frame on dut_a; optional stall on one window and optional stray start pulse.
  task automatic drive_frame(input int stall_idx, input int stall_len, input int poke_idx);
    int cyc, stall_cnt;
    bit poked;
    logic [71:0] snap_d;
    logic [2:0]  snap_r, snap_c;
    n_hs = 0; done_cyc = -1; first_valid_cyc = -1; done_pulses = 0;
    busy_at_done = 1'b1; frozen_ok = 1'b1;
    stall_cnt = 0; poked = 1'b0; snap_d = '0; snap_r = '0; snap_c = '0;
    win_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 1000 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
      if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      win_ready = 1'b1;
      if (win_valid && n_hs == stall_idx && stall_cnt <= stall_len) begin
        if (stall_cnt == 0) begin
          snap_d = win_data; snap_r = win_row; snap_c = win_col;
        end else if (win_data !== snap_d || win_row !== snap_r || win_col !== snap_c || win_valid !== 1'b1) begin
          frozen_ok = 1'b0;
        end
        if (stall_cnt < stall_len) win_ready = 1'b0;
        stall_cnt++;
      end
      if (win_valid && win_ready) begin
        if (n_hs < 64) begin
          hs_row[n_hs] = int'(win_row); hs_col[n_hs] = int'(win_col);
          hs_cyc[n_hs] = cyc; hs_data[n_hs] = win_data;
        end
        n_hs++;
      end
      start = 1'b0;
      if (poke_idx >= 0 && !poked && n_hs == poke_idx && busy && !win_valid) begin
        start = 1'b1; poked = 1'b1;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0;
    win_ready = 1'b0; win_ready_b = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({busy, done, win_valid, rd_addr, win_row, win_col} !== 15'd0) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %h want 0", {busy, done, win_valid, rd_addr, win_row, win_col});
    end
    n_checks++;
    if (win_data !== 72'd0) begin
      n_fail++; $display("FAIL reset_data_a: got %h want 0", win_data);
    end
    n_checks++;
    if ({busy_b, done_b, win_valid_b, rd_addr_b, win_row_b, win_col_b, win_data_b} !== 45'd0) begin
      n_fail++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, win_valid_b, rd_addr_b, win_row_b, win_col_b, win_data_b});
    end
    rst = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({busy, win_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_start: got %b want 000", {busy, win_valid, done});
    end
  endtask

  task automatic test_full_run();
    drive_frame(-1, 0, -1);
    n_checks++;
    if (first_valid_cyc != 10) begin
      n_fail++; $display("FAIL first_valid_cycle: got %0d want 10", first_valid_cyc);
    end
    n_checks++;
    if (n_hs != 36) begin
      n_fail++; $display("FAIL handshake_count: got %0d want 36", n_hs);
    end
    n_checks++;
    if (hs_data[0] !== 72'h12_11_10_0A_09_08_02_01_00) begin
      n_fail++; $display("FAIL first_taps: got %h want 121110_0a0908_020100", hs_data[0]);
    end
    for (int i = 0; i < 36 && i < n_hs; i++) begin
      n_checks++;
      if (hs_row[i] != i / 6 || hs_col[i] != i % 6 || hs_cyc[i] != 10 + 10 * i) begin
        n_fail++; $display("FAIL order_%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                           i, hs_row[i], hs_col[i], hs_cyc[i], i / 6, i % 6, 10 + 10 * i);
      end
      n_checks++;
      if (hs_data[i] !== exp_a(i / 6, i % 6)) begin
        n_fail++; $display("FAIL taps_%0d: got %h want %h", i, hs_data[i], exp_a(i / 6, i % 6));
      end
    end
    n_checks++;
    if (hs_data[35] !== 72'h3F3E3D_373635_2F2E2D) begin
      n_fail++; $display("FAIL last_taps: got %h want 3f3e3d_373635_2f2e2d", hs_data[35]);
    end
    n_checks++;
    if (done_cyc != 361 || done_pulses != 1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got cyc %0d pulses %0d busy %b want 361 1 0",
                         done_cyc, done_pulses, busy_at_done);
    end
  endtask

  task automatic test_backpressure();
    drive_frame(15, 5, -1);
    n_checks++;
    if (frozen_ok !== 1'b1) begin
      n_fail++; $display("FAIL hold_frozen: got %b want 1", frozen_ok);
    end
    n_checks++;
    if (n_hs != 36) begin
      n_fail++; $display("FAIL bp_count: got %0d want 36", n_hs);
    end
    n_checks++;
    if (hs_row[15] != 2 || hs_col[15] != 3 || hs_cyc[15] != 165 || hs_data[15] !== exp_a(2, 3)) begin
      n_fail++; $display("FAIL bp_stalled_win: got (%0d,%0d)@%0d %h want (2,3)@165 %h",
                         hs_row[15], hs_col[15], hs_cyc[15], hs_data[15], exp_a(2, 3));
    end
    n_checks++;
    if (hs_row[16] != 2 || hs_col[16] != 4 || hs_cyc[16] != 175) begin
      n_fail++; $display("FAIL bp_next_win: got (%0d,%0d)@%0d want (2,4)@175", hs_row[16], hs_col[16], hs_cyc[16]);
    end
    n_checks++;
    if (done_cyc != 366 || done_pulses != 1) begin
      n_fail++; $display("FAIL bp_done: got cyc %0d pulses %0d want 366 1", done_cyc, done_pulses);
    end
  endtask

  task automatic test_start_ignored();
    drive_frame(-1, 0, 7);
    n_checks++;
    if (n_hs != 36) begin
      n_fail++; $display("FAIL restart_count: got %0d want 36", n_hs);
    end
    for (int i = 0; i < 36 && i < n_hs; i++) begin
      n_checks++;
      if (hs_row[i] != i / 6 || hs_col[i] != i % 6 || hs_cyc[i] != 10 + 10 * i || hs_data[i] !== exp_a(i / 6, i % 6)) begin
        n_fail++; $display("FAIL restart_order_%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                           i, hs_row[i], hs_col[i], hs_cyc[i], i / 6, i % 6, 10 + 10 * i);
      end
    end
    n_checks++;
    if (done_cyc != 361 || done_pulses != 1) begin
      n_fail++; $display("FAIL restart_done: got cyc %0d pulses %0d want 361 1", done_cyc, done_pulses);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    win_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk); #1;
    // Cycle 25: tap 4 (kr=1,kc=1) of window (0,2) reads address 11
    n_checks++;
    if (busy !== 1'b1 || win_valid !== 1'b0 || win_col !== 3'd2 || rd_addr !== 6'd11) begin
      n_fail++; $display("FAIL mid_position: got busy %b valid %b col %0d addr %0d want 1 0 2 11",
                         busy, win_valid, win_col, rd_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, win_valid, rd_addr, win_row, win_col} !== 15'd0 || win_data !== 72'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h %h want 0 0",
                         {busy, done, win_valid, rd_addr, win_row, win_col}, win_data);
    end
    rst = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || win_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_quiet: got %b want 1", quiet);
    end
    drive_frame(-1, 0, -1);
    n_checks++;
    if (n_hs != 36 || first_valid_cyc != 10 || hs_row[0] != 0 || hs_col[0] != 0) begin
      n_fail++; $display("FAIL mid_restart: got n %0d first %0d (%0d,%0d) want 36 10 (0,0)",
                         n_hs, first_valid_cyc, hs_row[0], hs_col[0]);
    end
    n_checks++;
    if (hs_data[0] !== 72'h12_11_10_0A_09_08_02_01_00) begin
      n_fail++; $display("FAIL mid_restart_taps: got %h want 121110_0a0908_020100", hs_data[0]);
    end
  endtask

  task automatic test_small_geometry();
    int cyc, n, first, dcyc;
    n = 0; first = -1; dcyc = -1;
    win_ready_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 1;
    while (cyc < 300 && dcyc < 0) begin
      if (win_valid_b && first < 0) first = cyc;
      if (win_valid_b) begin
        n_checks++;
        if (win_row_b !== 2'(n / 4) || win_col_b !== 3'(n % 4) || cyc != 5 + 5 * n) begin
          n_fail++; $display("FAIL small_order_%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                             n, win_row_b, win_col_b, cyc, n / 4, n % 4, 5 + 5 * n);
        end
        if (n == 11) begin
          n_checks++;
          if (win_data_b !== 32'h13_12_0E_0D) begin
            n_fail++; $display("FAIL small_taps_2_3: got %h want 13120e0d", win_data_b);
          end
        end
        n++;
      end
      if (done_b) dcyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (n != 12 || first != 5 || dcyc != 61) begin
      n_fail++; $display("FAIL small_summary: got n %0d first %0d done %0d want 12 5 61", n, first, dcyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) buf_a[i] = 8'(i);
    for (int i = 0; i < 20; i++) buf_b[i] = 8'(i);
    test_reset();
    test_full_run();
    repeat (2) @(posedge clk);
    #1;
    test_backpressure();
    repeat (2) @(posedge clk);
    #1;
    test_start_ignored();
    repeat (2) @(posedge clk);
    #1;
    test_reset_mid();
    test_small_geometry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
